// File: rtl/noc_input_unit_if.sv
// Bundles the upstream flit link and the crossbar request/grant signals for one input unit.
// slave is the input unit's side; master is the side that drives the link and the grant.
interface noc_input_unit_if #(
    parameter int PORTS = 2,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int DW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] xb_data;
    logic [DW-1:0]    xb_dest;
    logic             xb_dest_en;
    logic             xb_ack;
    logic             xb_bp;
    logic [CW-1:0]    count;

    modport slave (
        input  in_data, in_valid, in_last, xb_ack, xb_bp,
        output in_ready, xb_data, xb_dest, xb_dest_en, count
    );

    modport master (
        output in_data, in_valid, in_last, xb_ack, xb_bp,
        input  in_ready, xb_data, xb_dest, xb_dest_en, count
    );
endinterface

// File: rtl/noc_input_unit.sv
// Per-port ingress stage: flit FIFO plus a route FSM that keeps a packet's destination
// from its header flit through its tail flit.
module noc_input_unit #(
    parameter int PORTS    = 2,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int DEST_LSB = 0
) (
    input  logic            clk,
    input  logic            rst,
    noc_input_unit_if.slave bus
);
    localparam int DW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {HEAD, BODY} state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  dest_q, dest_d;
    logic [WIDTH:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           push, pop, empty, full;
    logic [WIDTH:0] head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Full is judged on registered occupancy only, so a same-cycle pop never admits a push.
    assign push = bus.in_valid && !full;
    assign pop  = !empty && bus.xb_ack && !bus.xb_bp;
    assign head = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_last, bus.in_data};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= HEAD;
            dest_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        bus.xb_dest = head[DEST_LSB +: DW];
        case (state_q)
            HEAD: begin
                if (pop && !head[WIDTH]) begin
                    state_d = BODY;
                    dest_d  = head[DEST_LSB +: DW];
                end
            end
            BODY: begin
                bus.xb_dest = dest_q;
                if (pop && head[WIDTH]) begin
                    state_d = HEAD;
                end
            end
            default: state_d = HEAD;
        endcase
    end

    assign bus.xb_data    = head[WIDTH-1:0];
    assign bus.xb_dest_en = !empty;
    assign bus.in_ready   = !full;
    assign bus.count      = count_q;
endmodule
